// File: rtl/astar_pkg.sv
// Shared grid constants, direction codes and neighbour stepping for the A* engine and its consumers.
package astar_pkg;

  localparam int unsigned GRID_SIZE  = 16;
  localparam int unsigned COORD_BITS = 4;
  localparam int unsigned NODES      = GRID_SIZE * GRID_SIZE;
  localparam int unsigned NODE_BITS  = 2 * COORD_BITS;

  typedef logic [COORD_BITS-1:0] coord_t;

  localparam logic [3:0] DIR_UP    = 4'd0;
  localparam logic [3:0] DIR_DOWN  = 4'd1;
  localparam logic [3:0] DIR_LEFT  = 4'd2;
  localparam logic [3:0] DIR_RIGHT = 4'd3;
  localparam logic [3:0] DIR_UL    = 4'd4;
  localparam logic [3:0] DIR_UR    = 4'd5;
  localparam logic [3:0] DIR_DL    = 4'd6;
  localparam logic [3:0] DIR_DR    = 4'd7;
  localparam logic [3:0] DIR_START = 4'd8;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   in_bounds;
  } nbr_t;

  function automatic logic [NODE_BITS-1:0] node_index(input coord_t x, input coord_t y);
    return {y, x};
  endfunction

  // y grows downward, so "up" is y-1; off-grid neighbours never wrap.
  function automatic nbr_t nbr_step(input coord_t x, input coord_t y, input logic [2:0] idx);
    int   dx;
    int   dy;
    int   sx;
    int   sy;
    nbr_t r;
    dx = 0;
    dy = 0;
    case (idx)
      3'd0: dy = -1;
      3'd1: dy = 1;
      3'd2: dx = -1;
      3'd3: dx = 1;
      3'd4: begin dx = -1; dy = -1; end
      3'd5: begin dx = 1;  dy = -1; end
      3'd6: begin dx = -1; dy = 1;  end
      default: begin dx = 1; dy = 1; end
    endcase
    sx = int'(x) + dx;
    sy = int'(y) + dy;
    r.in_bounds = (sx >= 0) && (sx < int'(GRID_SIZE)) && (sy >= 0) && (sy < int'(GRID_SIZE));
    r.x = sx[COORD_BITS-1:0];
    r.y = sy[COORD_BITS-1:0];
    return r;
  endfunction

endpackage

// File: rtl/astar_nbr_gen.sv
// Combinational neighbour generator: cell plus scan index to neighbour cell and bounds flag.
module astar_nbr_gen
  import astar_pkg::*;
(
  input  logic [COORD_BITS-1:0] x,
  input  logic [COORD_BITS-1:0] y,
  input  logic [2:0]            idx,
  output logic [COORD_BITS-1:0] nx,
  output logic [COORD_BITS-1:0] ny,
  output logic                  in_bounds
);

  nbr_t n;

  always_comb begin
    n         = nbr_step(x, y, idx);
    nx        = n.x;
    ny        = n.y;
    in_bounds = n.in_bounds;
  end

endmodule

// File: rtl/astar_path_tracer.sv
// Walks the engine's unordered path bitmap from start to goal and streams ordered waypoints.
module astar_path_tracer
  import astar_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [COORD_BITS-1:0]        start_x,
  input  logic [COORD_BITS-1:0]        start_y,
  input  logic [COORD_BITS-1:0]        goal_x,
  input  logic [COORD_BITS-1:0]        goal_y,
  input  logic [GRID_SIZE*GRID_SIZE-1:0] path_map,
  input  logic [7:0]                   path_length,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COORD_BITS-1:0]        out_x,
  output logic [COORD_BITS-1:0]        out_y,
  output logic [3:0]                   out_dir,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         length_mismatch,
  output logic [7:0]                   steps_emitted
);

  typedef enum logic [2:0] {IDLE, CHECK, EMIT, SCAN, FINISH, ERR} state_t;

  state_t                state;
  logic [NODES-1:0]      map_q;
  logic [NODES-1:0]      visited;
  logic [COORD_BITS-1:0] sx_q, sy_q, gx_q, gy_q;
  logic [7:0]            plen_q;
  logic [2:0]            idx;
  logic [COORD_BITS-1:0] nx, ny;
  logic                  nbr_ok;
  logic [NODE_BITS-1:0]  nbr_node;
  logic                  cand_ok;

  // out_x/out_y double as the current cell, so the scan is always relative to the last waypoint.
  astar_nbr_gen u_nbr (
    .x         (out_x),
    .y         (out_y),
    .idx       (idx),
    .nx        (nx),
    .ny        (ny),
    .in_bounds (nbr_ok)
  );

  assign nbr_node = node_index(nx, ny);
  assign cand_ok  = nbr_ok && map_q[nbr_node] && !visited[nbr_node];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      map_q           <= '0;
      visited         <= '0;
      sx_q            <= '0;
      sy_q            <= '0;
      gx_q            <= '0;
      gy_q            <= '0;
      plen_q          <= '0;
      idx             <= '0;
      out_valid       <= 1'b0;
      out_x           <= '0;
      out_y           <= '0;
      out_dir         <= '0;
      out_last        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      length_mismatch <= 1'b0;
      steps_emitted   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            map_q           <= path_map;
            sx_q            <= start_x;
            sy_q            <= start_y;
            gx_q            <= goal_x;
            gy_q            <= goal_y;
            plen_q          <= path_length;
            error           <= 1'b0;
            length_mismatch <= 1'b0;
            steps_emitted   <= '0;
            busy            <= 1'b1;
            state           <= CHECK;
          end
        end
        CHECK: begin
          if (!map_q[node_index(sx_q, sy_q)] || !map_q[node_index(gx_q, gy_q)]) begin
            state <= ERR;
          end else begin
            out_x     <= sx_q;
            out_y     <= sy_q;
            out_dir   <= DIR_START;
            out_last  <= (sx_q == gx_q) && (sy_q == gy_q);
            visited   <= '0;
            visited[node_index(sx_q, sy_q)] <= 1'b1;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid     <= 1'b0;
            steps_emitted <= (steps_emitted == 8'hFF) ? 8'hFF : steps_emitted + 8'd1;
            if (out_last) begin
              state <= FINISH;
            end else if (({1'b0, steps_emitted} + 9'd1) == 9'(MAX_STEPS)) begin
              state <= ERR;
            end else begin
              idx   <= '0;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (cand_ok) begin
            out_x             <= nx;
            out_y             <= ny;
            out_dir           <= {1'b0, idx};
            out_last          <= (nx == gx_q) && (ny == gy_q);
            visited[nbr_node] <= 1'b1;
            out_valid         <= 1'b1;
            state             <= EMIT;
          end else if (idx == 3'd7) begin
            state <= ERR;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        FINISH: begin
          done            <= 1'b1;
          busy            <= 1'b0;
          length_mismatch <= (steps_emitted != plen_q);
          state           <= IDLE;
        end
        ERR: begin
          error     <= 1'b1;
          done      <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_astar_path_tracer.sv
// Randomized and directed bench for astar_path_tracer against a queue-based path-walk reference.
module tb_astar_path_tracer;
  import astar_pkg::*;

  localparam int unsigned MAX_STEPS = 20;
  localparam int G = int'(GRID_SIZE);

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   start_x, start_y, goal_x, goal_y;
  logic [255:0] path_map;
  logic [7:0]   path_length;
  logic         out_valid, out_ready, out_last, busy, done, error, length_mismatch;
  logic [3:0]   out_x, out_y, out_dir;
  logic [7:0]   steps_emitted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int x;
    int y;
    int d;
    bit last;
  } wp_t;

  wp_t exp_q[$];
  wp_t got_q[$];
  bit  exp_err;
  bit  exp_mm;
  int  DX[8] = '{0, 0, -1, 1, -1, 1, -1, 1};
  int  DY[8] = '{-1, 1, 0, 0, -1, -1, 1, 1};

  always #5 clk = ~clk;

  astar_path_tracer #(.MAX_STEPS(MAX_STEPS)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .start_x         (start_x),
    .start_y         (start_y),
    .goal_x          (goal_x),
    .goal_y          (goal_y),
    .path_map        (path_map),
    .path_length     (path_length),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_x           (out_x),
    .out_y           (out_y),
    .out_dir         (out_dir),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .length_mismatch (length_mismatch),
    .steps_emitted   (steps_emitted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: greedy walk, first unvisited marked in-grid neighbour in the fixed direction order.
  function automatic void model(input logic [255:0] m, input int sx, input int sy,
                                input int gx, input int gy, input int plen);
    bit vis[256];
    int cx, cy, d, nx, ny;
    bit found;
    exp_q.delete();
    exp_err = 0;
    exp_mm  = 0;
    if (!m[sy*G+sx] || !m[gy*G+gx]) begin
      exp_err = 1;
      return;
    end
    cx = sx; cy = sy; d = 8;
    vis[cy*G+cx] = 1;
    for (int step = 0; step < 300; step++) begin
      exp_q.push_back('{cx, cy, d, bit'(cx == gx && cy == gy)});
      if (cx == gx && cy == gy) begin
        exp_mm = (exp_q.size() != plen);
        return;
      end
      if (exp_q.size() == int'(MAX_STEPS)) begin
        exp_err = 1;
        return;
      end
      found = 0;
      for (int k = 0; k < 8 && !found; k++) begin
        nx = cx + DX[k];
        ny = cy + DY[k];
        if (nx >= 0 && nx < G && ny >= 0 && ny < G && m[ny*G+nx] && !vis[ny*G+nx]) begin
          found = 1; cx = nx; cy = ny; d = k; vis[ny*G+nx] = 1;
        end
      end
      if (!found) begin
        exp_err = 1;
        return;
      end
    end
  endfunction

  task automatic run_trace(input logic [255:0] m, input int sx, input int sy, input int gx,
                           input int gy, input int plen, input int mode, input bit garble,
                           input string tag, output int done_cyc);
    bit held, fin, r;
    int wait_n;
    logic [12:0] hold_val;
    model(m, sx, sy, gx, gy, plen);
    got_q.delete();
    done_cyc = -1;
    @(negedge clk);
    path_map = m; start_x = sx[3:0]; start_y = sy[3:0];
    goal_x = gx[3:0]; goal_y = gy[3:0]; path_length = plen[7:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (garble) begin
      path_map = {8{$urandom}};
      start_x = 4'($urandom); goal_y = 4'($urandom);
    end
    held = 0; fin = 0; wait_n = 0; hold_val = '0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (held) begin
        check({tag, "_hold_valid"}, out_valid, 1);
        check({tag, "_hold_data"}, {out_x, out_y, out_dir, out_last}, hold_val);
      end
      if (done) begin
        fin = 1;
        done_cyc = cyc;
        start = 1'b0;
      end else begin
        if (out_valid) wait_n++; else wait_n = 0;
        case (mode)
          0: r = 1;
          1: r = bit'($urandom_range(0, 1));
          default: r = (wait_n > 5);
        endcase
        out_ready = r;
        held = out_valid && !r;
        hold_val = {out_x, out_y, out_dir, out_last};
        if (out_valid && r) got_q.push_back('{int'(out_x), int'(out_y), int'(out_dir), out_last});
        start = garble && busy && ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
    end
    if (!fin) begin
      check({tag, "_timeout"}, 0, 1);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check({tag, "_error"}, error, exp_err);
    check({tag, "_mismatch"}, length_mismatch, exp_err ? 0 : exp_mm);
    check({tag, "_steps"}, steps_emitted, exp_q.size());
    check({tag, "_busy"}, busy, 0);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_x"}, got_q[i].x, exp_q[i].x);
      check({tag, "_y"}, got_q[i].y, exp_q[i].y);
      check({tag, "_dir"}, got_q[i].d, exp_q[i].d);
      check({tag, "_last"}, 32'(got_q[i].last), 32'(exp_q[i].last));
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_xy"}, {out_x, out_y}, 0);
    check({tag, "_dir"}, out_dir, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_mismatch"}, length_mismatch, 0);
    check({tag, "_steps"}, steps_emitted, 0);
  endtask

  initial begin
    logic [255:0] m;
    int dc, x, y, nx, ny, sx, sy, len, n, k, plen, wait_n;
    bit ok;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    start_x = '0; start_y = '0; goal_x = '0; goal_y = '0;
    path_map = '0; path_length = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run_trace(256'hF, 0, 0, 3, 0, 4, 0, 0, "straight", dc);
    m = '0; m[0] = 1; m[17] = 1; m[34] = 1;
    run_trace(m, 0, 0, 2, 2, 3, 0, 0, "diagonal", dc);
    run_trace(256'hF, 0, 0, 3, 0, 4, 2, 0, "backpressure", dc);
    run_trace(256'hB, 0, 0, 3, 0, 4, 0, 0, "broken", dc);
    run_trace(256'h7, 0, 0, 3, 0, 4, 0, 0, "goal_clear", dc);
    check("goal_clear_latency", dc, 2);
    run_trace(256'hF, 0, 0, 3, 0, 5, 1, 0, "len_mismatch", dc);
    m = '0; m[5*G+7] = 1;
    run_trace(m, 7, 5, 7, 5, 1, 0, 0, "single_cell", dc);

    // Snake of 33 cells: row 0, then (15,1), then row 2 leftwards; runs into the step limit.
    m = '0;
    for (int i = 0; i < G; i++) begin m[i] = 1; m[2*G+i] = 1; end
    m[G+15] = 1;
    run_trace(m, 0, 0, 0, 2, 33, 0, 0, "max_steps", dc);

    // Abort in the middle of a neighbour scan.
    @(negedge clk);
    path_map = 256'hF; start_x = 0; start_y = 0; goal_x = 3; goal_y = 0;
    path_length = 4; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_valid) ok = 1;
      @(negedge clk);
    end
    check("mid_scan_reached", ok, 1);
    rst = 1'b1;
    #1;
    check_zero("mid_scan_reset");
    @(negedge clk);
    rst = 1'b0;
    run_trace(256'hF, 0, 0, 3, 0, 4, 0, 0, "after_reset", dc);

    for (int t = 0; t < 40; t++) begin
      m = '0;
      x = $urandom_range(0, 15); y = $urandom_range(0, 15);
      sx = x; sy = y; m[y*G+x] = 1; len = 1;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 7);
        nx = x + DX[k]; ny = y + DY[k];
        if (nx >= 0 && nx < G && ny >= 0 && ny < G && !m[ny*G+nx]) begin
          x = nx; y = ny; m[y*G+x] = 1; len++;
        end
      end
      if ($urandom_range(0, 4) == 0) m[$urandom_range(0, 255)] = 1'b1;
      plen = ($urandom_range(0, 6) == 0) ? len + 1 : len;
      wait_n = $urandom_range(0, 2);
      run_trace(m, sx, sy, x, y, plen, wait_n, bit'($urandom_range(0, 1)), "random", dc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
